// File: rtl/reg_op_seq.sv
// rtl/reg_op_seq.sv - four-state register-file operation sequencer (ADD/SUB/AND/MOV)
// Optional REG_OP_SEQ_R0_ZERO_EN: register 0 reads as zero and is never written.
module reg_op_seq #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [2:0]        src_a,
  input  logic [2:0]        src_b,
  input  logic [2:0]        dst,
  output logic [2:0]        rf_rd_addr_a,
  output logic [2:0]        rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_d_out_a,
  input  logic [DATA_W-1:0] rf_d_out_b,
  output logic              rf_wr,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        op_r;
  logic [2:0]        dst_r;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              carry_r;
  logic [DATA_W-1:0] rd_a_val;
  logic [DATA_W-1:0] rd_b_val;
  logic              wr_allowed;
  logic [DATA_W:0]   alu;

`ifdef REG_OP_SEQ_R0_ZERO_EN
  assign rd_a_val   = (rf_rd_addr_a == 3'd0) ? '0 : rf_d_out_a;
  assign rd_b_val   = (rf_rd_addr_b == 3'd0) ? '0 : rf_d_out_b;
  assign wr_allowed = (dst_r != 3'd0);
`else
  assign rd_a_val   = rf_d_out_a;
  assign rd_b_val   = rf_d_out_b;
  assign wr_allowed = 1'b1;
`endif

  // One extra bit holds the carry of ADD and the borrow of SUB.
  always_comb begin
    alu = '0;
    case (op_r)
      2'b00:   alu = {1'b0, opa} + {1'b0, opb};
      2'b01:   alu = {1'b0, opa} - {1'b0, opb};
      2'b10:   alu = {1'b0, opa & opb};
      default: alu = {1'b0, opa};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      op_r         <= 2'b00;
      dst_r        <= 3'd0;
      rf_rd_addr_a <= 3'd0;
      rf_rd_addr_b <= 3'd0;
      opa          <= '0;
      opb          <= '0;
      carry_r      <= 1'b0;
      rf_wr        <= 1'b0;
      rf_wr_addr   <= 3'd0;
      rf_d_in      <= '0;
      done         <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state        <= READ;
            req_ready    <= 1'b0;
            op_r         <= op;
            dst_r        <= dst;
            rf_rd_addr_a <= src_a;
            rf_rd_addr_b <= src_b;
          end
        end
        READ: begin
          state <= EXEC;
          opa   <= rd_a_val;
          opb   <= rd_b_val;
        end
        EXEC: begin
          state      <= WRITE;
          rf_d_in    <= alu[DATA_W-1:0];
          carry_r    <= alu[DATA_W];
          rf_wr      <= wr_allowed;
          rf_wr_addr <= dst_r;
          done       <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rf_wr     <= 1'b0;
          done      <= 1'b0;
          flag_z    <= (rf_d_in == '0);
          flag_c    <= carry_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_seq.sv
// tb/tb_reg_op_seq.sv - directed self-checking bench for reg_op_seq
module tb_reg_op_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [2:0]  src_a, src_b, dst;
  logic [2:0]  rf_rd_addr_a, rf_rd_addr_b;
  logic [15:0] rf_d_out_a, rf_d_out_b;
  logic        rf_wr;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_d_in;
  logic        done;
  logic        flag_z, flag_c;

  logic [15:0] rf [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_d_out_a = rf[rf_rd_addr_a];
  assign rf_d_out_b = rf[rf_rd_addr_b];

  always @(posedge clk) if (rf_wr) rf[rf_wr_addr] <= rf_d_in;

  reg_op_seq #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b),
    .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
    .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  task automatic do_op(input string name, input logic [1:0] o, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d, input logic exp_wr,
                       input logic [15:0] exp_data, input logic exp_z, input logic exp_c);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; op = o; src_a = a; src_b = b; dst = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rf_rd_addr_a !== a || rf_rd_addr_b !== b || req_ready !== 1'b0 || rf_wr !== 1'b0) begin
      errors++;
      $display("FAIL %s read_state: addr_a %0d addr_b %0d ready %b wr %b want %0d %0d 0 0",
               name, rf_rd_addr_a, rf_rd_addr_b, req_ready, rf_wr, a, b);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_wr !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s exec_state: wr %b done %b want 0 0", name, rf_wr, done);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_wr !== exp_wr || done !== 1'b1 || rf_wr_addr !== d || rf_d_in !== exp_data) begin
      errors++;
      $display("FAIL %s write_state: wr %b done %b addr %0d data %h want %b 1 %0d %h",
               name, rf_wr, done, rf_wr_addr, rf_d_in, exp_wr, d, exp_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_wr !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || flag_z !== exp_z || flag_c !== exp_c) begin
      errors++;
      $display("FAIL %s after_write: wr %b done %b ready %b z %b c %b want 0 0 1 %b %b",
               name, rf_wr, done, req_ready, flag_z, flag_c, exp_z, exp_c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; op = 2'b00; src_a = 3'd0; src_b = 3'd0; dst = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rf_wr !== 1'b0 || done !== 1'b0 || flag_z !== 1'b0 || flag_c !== 1'b0 ||
        rf_rd_addr_a !== 3'd0 || rf_rd_addr_b !== 3'd0 || rf_wr_addr !== 3'd0 || rf_d_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ready %b wr %b done %b z %b c %b ra %0d rb %0d wa %0d d %h want 1 0 0 0 0 0 0 0 0000",
               req_ready, rf_wr, done, flag_z, flag_c, rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, rf_d_in);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add();
    rf[1] = 16'h1234; rf[2] = 16'h0F0F; rf[3] = 16'h0000;
    do_op("add", 2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 16'h2143, 1'b0, 1'b0);
    checks++;
    if (rf[3] !== 16'h2143) begin
      errors++; $display("FAIL add_rf: got %h want 2143", rf[3]);
    end
  endtask

  task automatic test_sub_and();
    rf[1] = 16'h0001; rf[2] = 16'h0002;
    do_op("sub", 2'b01, 3'd1, 3'd2, 3'd4, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    do_op("and", 2'b10, 3'd1, 3'd2, 3'd6, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("mov", 2'b11, 3'd4, 3'd1, 3'd7, 1'b1, 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_same_dst();
    rf[5] = 16'h8000;
    do_op("wrap", 2'b00, 3'd5, 3'd5, 3'd5, 1'b1, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (rf[5] !== 16'h0000) begin
      errors++; $display("FAIL wrap_rf: got %h want 0000", rf[5]);
    end
  endtask

  task automatic test_mid_reset();
    int wr_seen = 0;
    rf[1] = 16'h0011; rf[2] = 16'h0022; rf[7] = 16'h5555;
    @(negedge clk);
    req_valid = 1'b1; op = 2'b00; src_a = 3'd1; src_b = 3'd2; dst = 3'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rf_wr !== 1'b0 || flag_z !== 1'b0 || flag_c !== 1'b0 || rf_rd_addr_a !== 3'd0) begin
      errors++;
      $display("FAIL midreset_state: ready %b wr %b z %b c %b ra %0d want 1 0 0 0 0",
               req_ready, rf_wr, flag_z, flag_c, rf_rd_addr_a);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      if (rf_wr) wr_seen++;
    end
    checks++;
    if (wr_seen != 0 || rf[7] !== 16'h5555 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_abort: writes %0d r7 %h ready %b want 0 5555 1", wr_seen, rf[7], req_ready);
    end
  endtask

  task automatic test_r0();
    rf[0] = 16'hAAAA;
`ifdef REG_OP_SEQ_R0_ZERO_EN
    do_op("r0_mov", 2'b11, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
`else
    do_op("r0_mov", 2'b11, 3'd0, 3'd0, 3'd0, 1'b1, 16'hAAAA, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    int nacc = 0;
    int ndone = 0;
    int bad = 0;
    int last_acc = -1;
    logic prev_done = 1'b0;
    rf[1] = 16'h0101;
    @(negedge clk);
    req_valid = 1'b1; op = 2'b11; src_a = 3'd1; src_b = 3'd1; dst = 3'd6;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        if (last_acc >= 0 && i - last_acc != 4) bad++;
        last_acc = i;
        nacc++;
      end
      if (done) begin
        ndone++;
        if (prev_done) bad++;
      end
      prev_done = done;
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (nacc != 4 || ndone != 4 || bad != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: accepts %0d dones %0d bad %0d ready %b want 4 4 0 1",
               nacc, ndone, bad, req_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    test_reset();
    test_add();
    test_sub_and();
    test_wrap_same_dst();
    test_mid_reset();
    test_r0();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_op_seq.md
REG_OP_SEQ -- requirements
Module: reg_op_seq

Interface
REQ-001 SHALL have parameter: DATA_W, 16, datapath and register width.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  operation request present.
REQ-005 SHALL have port: req_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port: op  input  2  00 ADD, 01 SUB, 10 AND, 11 MOV (dst = A).
REQ-007 SHALL have port: src_a, src_b, dst  input  3 each  register-file addresses.
REQ-008 SHALL have port: rf_rd_addr_a, rf_rd_addr_b  output  3 each  read addresses to register file.
REQ-009 SHALL have port: rf_d_out_a, rf_d_out_b  input  DATA_W each  combinational read data from register file.
REQ-010 SHALL have port: rf_wr  output  1  register-file write enable.
REQ-011 SHALL have port: rf_wr_addr  output  3  write address.
REQ-012 SHALL have port: rf_d_in  output  DATA_W  write data.
REQ-013 SHALL have port: done  output  1  one-cycle pulse on write-back.
REQ-014 SHALL have port: flag_z, flag_c  output  1 each  zero and carry/borrow of last completed op.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle per state outside IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; request accepted on edge where req_valid & req_ready; op/src_a/src_b/dst latched then.
REQ-017 req_valid while not in IDLE SHALL be ignored; no queuing.
REQ-018 In READ, rf_rd_addr_a/b SHALL equal latched src_a/src_b; rf_d_out_a/b latched into operand registers at end of READ.
REQ-019 Outside READ, read addresses SHALL hold last driven values.
REQ-020 In EXEC, result SHALL be computed DATA_W+1 wide: ADD A+B, SUB A-B (carry bit = borrow), AND A&B (carry 0), MOV A (carry 0); result and carry registered at end of EXEC.
REQ-021 In WRITE, rf_wr=1, rf_wr_addr=latched dst, rf_d_in=result, done=1; rf_wr and done SHALL be 0 in every other state.
REQ-022 flag_z (result==0) and flag_c SHALL update at end of WRITE and hold until next write-back.
REQ-023 Latency: request accepted at edge N -> rf_wr/done high during cycle N+3; next acceptance no earlier than edge N+4.
REQ-024 dst equal to src_a or src_b SHALL be legal; operands are already latched, write-back uses old values.
REQ-025 Arithmetic SHALL wrap modulo 2^DATA_W; no saturation.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE, rf_wr=0, done=0, req_ready=1, flags=0, read/write addresses=0, rf_d_in=0, operands=0.
REQ-027 Reset mid-operation SHALL abort it with no write-back; first accept possible on first edge after deassertion.

Configuration
REQ-028 Macro REG_OP_SEQ_R0_ZERO_EN SHALL, when defined, treat register 0 as constant zero: operand from address 0 read as 0 regardless of rf_d_out, and WRITE with dst=0 keeps rf_wr=0 (done and flags still update).
REQ-029 Without REG_OP_SEQ_R0_ZERO_EN, register 0 SHALL behave as any other register.

Verification
REQ-030 Reset low mid-EXEC -> rf_wr never asserts, req_ready=1 at once, flags 0.
REQ-031 R1=0x1234, R2=0x0F0F, ADD src_a=1 src_b=2 dst=3 -> rf_wr in cycle N+3, addr 3, data 0x2143, flag_z=0, flag_c=0.
REQ-032 R1=0x0001, R2=0x0002, SUB dst=4 -> data 0xFFFF, flag_c=1; then AND R1,R2 -> data 0x0000, flag_z=1, flag_c=0.
REQ-033 req_valid held high continuously -> accepts exactly every 4 cycles, done pulses exactly one cycle each.
REQ-034 R5=0x8000 ADD R5,R5 dst=5 -> data 0x0000, flag_c=1, flag_z=1, write to addr 5.
REQ-035 With REG_OP_SEQ_R0_ZERO_EN, R0 model=0xAAAA, MOV src_a=0 dst=0 -> rf_wr stays 0, done=1, flag_z=1; without macro -> rf_wr=1, data 0xAAAA.
